mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline MEM stage. Sits between the EX/MEM pipeline register and the WB stage.
- Consumes EX/MEM outputs and performs data-memory accesses over a req/ack handshake to a variable-latency data memory.
- Stalls upstream stages while an access is outstanding.
- Drives the registered MEM/WB pipeline outputs consumed by write-back.

Parameters:
- TIMEOUT, 255, maximum BUSY cycles to wait for dmem_ack_i before aborting; legal range 1..65535.
- CNT_W, 16, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous active-high reset
- ALUResult_i  input  32  address for memory ops; pass-through result otherwise
- VALUResult_i  input  32  vector ALU result, passed through
- RDData_i  input  32  store data
- RDaddr_i  input  5  destination register
- RegWrite_i  input  1  writeback enable
- MemToReg_i  input  1  select memory data at WB
- MemRead_i  input  1  load
- MemWrite_i  input  1  store
- instr_i  input  32  instruction word
- stall_o  output  1  hold EX/MEM and all earlier stages
- dmem_req_o  output  1  memory request
- dmem_we_o  output  1  1 = write
- dmem_addr_o  output  32  word-aligned address
- dmem_wdata_o  output  32  write data
- dmem_ack_i  input  1  access complete
- dmem_rdata_i  input  32  read data, valid when dmem_ack_i=1
- ALUResult_o  output  32  MEM/WB ALU result
- VALUResult_o  output  32  MEM/WB vector result
- MemData_o  output  32  MEM/WB load data
- RDaddr_o  output  5  MEM/WB destination register
- RegWrite_o  output  1  MEM/WB writeback enable
- MemToReg_o  output  1  MEM/WB select
- instr_o  output  32  MEM/WB instruction word
- misalign_o  output  1  one-cycle pulse: misaligned memory op
- timeout_o  output  1  one-cycle pulse: access aborted

Behaviour:
- Reset:
  - Applies asynchronously; all outputs go to 0, state goes to IDLE, counter clears.
  - dmem_req_o drops immediately, including mid-access.
  - After reset releases, no request is reissued for the interrupted access.
- Definitions:
  - memop = MemRead_i | MemWrite_i.
  - aligned = (ALUResult_i[1:0] == 0).
  - If MemRead_i and MemWrite_i are both 1, the op is a store: dmem_we_o=1 and load data is not captured.
- State IDLE:
  - Non-memop: on the clock edge, MEM/WB outputs load the inputs; MemData_o loads 0; stall_o=0. Latency is 1 cycle.
  - memop && !aligned: no request is issued; stall_o=0; outputs are registered as non-memop except RegWrite_o=0 and MemToReg_o=0; misalign_o pulses for 1 cycle.
  - memop && aligned: stall_o=1 combinationally in the same cycle; capture address, wdata and we; go to BUSY; the MEM/WB outputs load a bubble.
- Bubble: RegWrite_o=0, MemToReg_o=0, RDaddr_o=0, instr_o=0; the data outputs hold their previous values.
- State BUSY:
  - dmem_req_o=1 with addr, we and wdata held stable.
  - stall_o=1; MEM/WB outputs load a bubble every cycle.
  - The counter increments each cycle.
  - dmem_ack_i sampled high on a rising edge (it may be high in the first BUSY cycle): latch dmem_rdata_i if the op is a load; go to DONE; clear the counter.
  - Counter reaches TIMEOUT with no ack: drop the request, set the abort flag, go to DONE.
- dmem_ack_i while dmem_req_o=0 is ignored.
- State DONE:
  - stall_o=0; dmem_req_o=0.
  - On the clock edge, MEM/WB outputs load the still-held EX/MEM inputs; MemData_o loads the latched read data (0 for a store).
  - Go to IDLE.
  - If the abort flag is set: RegWrite_o=0, MemToReg_o=0, MemData_o=0; timeout_o pulses during the DONE cycle.
- Timing: minimum aligned-access occupancy is 3 cycles (IDLE detect, BUSY with ack, DONE). The next instruction is accepted in the cycle after DONE.
- Back-to-back memops cause no overlap: the request drops for at least one cycle (DONE) between accesses.
- dmem_addr_o is the captured ALUResult_i with bits [1:0] forced to 0.
- dmem_addr_o, dmem_wdata_o and dmem_we_o are 0 whenever dmem_req_o=0.

Test Plan:
- Reset then ALU op: ALUResult_i=0x1234, RDaddr_i=5, RegWrite_i=1 -> next edge ALUResult_o=0x1234, RDaddr_o=5, RegWrite_o=1; stall_o never asserts.
- Load, immediate ack: addr 0x100, memory returns 0xDEADBEEF with ack in the first BUSY cycle, MemToReg_i=1 -> stall_o high 2 cycles; MemData_o=0xDEADBEEF, RegWrite_o=1 after the DONE edge; exactly one RegWrite_o=1 cycle.
- Store, 4-cycle ack delay: addr 0x200, data 0xA5A5A5A5 -> dmem_req_o high 4 cycles with constant addr, we and wdata; stall_o high 5 cycles; MEM/WB bubbles throughout.
- Misaligned load: addr 0x102 -> no dmem_req_o; misalign_o one pulse; RegWrite_o=0; stall_o=0.
- Timeout with TIMEOUT=4 and ack never asserted -> request drops after 4 BUSY cycles; timeout_o pulses; RegWrite_o=0.
- rst_i asserted in the second BUSY cycle -> dmem_req_o and stall_o go 0 asynchronously before the next edge; state returns to IDLE; a later ack is ignored.

Source files
------------

// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues data-memory accesses over a req/ack handshake,
// stalls upstream while an access is outstanding and registers MEM/WB outputs.
module mem_stage #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] VALUResult_i,
  input  logic [31:0] RDData_i,
  input  logic [4:0]  RDaddr_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] instr_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [31:0] ALUResult_o,
  output logic [31:0] VALUResult_o,
  output logic [31:0] MemData_o,
  output logic [4:0]  RDaddr_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic [31:0] instr_o,
  output logic        misalign_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               abort_q, abort_d;

  logic [31:0]        alu_q, alu_d;
  logic [31:0]        valu_q, valu_d;
  logic [31:0]        memdata_q, memdata_d;
  logic [4:0]         rdaddr_q, rdaddr_d;
  logic               regwrite_q, regwrite_d;
  logic               memtoreg_q, memtoreg_d;
  logic [31:0]        instr_q, instr_d;
  logic               misalign_q, misalign_d;

  logic               stall_c;
  logic               memop;
  logic               aligned;
  logic [CNT_W-1:0]   cnt_inc;

  assign memop   = MemRead_i | MemWrite_i;
  assign aligned = (ALUResult_i[1:0] == 2'b00);
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = we_q;
    rdata_d    = rdata_q;
    abort_d    = abort_q;
    alu_d      = alu_q;
    valu_d     = valu_q;
    memdata_d  = memdata_q;
    rdaddr_d   = rdaddr_q;
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    instr_d    = instr_q;
    misalign_d = 1'b0;
    stall_c    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (memop && aligned) begin
          stall_c    = 1'b1;
          addr_d     = {ALUResult_i[31:2], 2'b00};
          wdata_d    = RDData_i;
          we_d       = MemWrite_i;
          rdata_d    = '0;
          abort_d    = 1'b0;
          cnt_d      = '0;
          state_d    = S_BUSY;
          regwrite_d = 1'b0;
          memtoreg_d = 1'b0;
          rdaddr_d   = '0;
          instr_d    = '0;
        end else begin
          alu_d      = ALUResult_i;
          valu_d     = VALUResult_i;
          memdata_d  = '0;
          rdaddr_d   = RDaddr_i;
          regwrite_d = RegWrite_i & ~memop;
          memtoreg_d = MemToReg_i & ~memop;
          instr_d    = instr_i;
          misalign_d = memop;
        end
      end

      S_BUSY: begin
        stall_c    = 1'b1;
        regwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        rdaddr_d   = '0;
        instr_d    = '0;
        // An ack on the final allowed cycle still wins over the timeout.
        if (dmem_ack_i) begin
          if (!we_q) rdata_d = dmem_rdata_i;
          cnt_d   = '0;
          state_d = S_DONE;
        end else if (cnt_inc == TIMEOUT_C) begin
          abort_d = 1'b1;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_DONE: begin
        alu_d      = ALUResult_i;
        valu_d     = VALUResult_i;
        memdata_d  = abort_q ? 32'h0 : rdata_q;
        rdaddr_d   = RDaddr_i;
        regwrite_d = RegWrite_i & ~abort_q;
        memtoreg_d = MemToReg_i & ~abort_q;
        instr_d    = instr_i;
        state_d    = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      abort_q    <= 1'b0;
      alu_q      <= '0;
      valu_q     <= '0;
      memdata_q  <= '0;
      rdaddr_q   <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      instr_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
      abort_q    <= abort_d;
      alu_q      <= alu_d;
      valu_q     <= valu_d;
      memdata_q  <= memdata_d;
      rdaddr_q   <= rdaddr_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      instr_q    <= instr_d;
      misalign_q <= misalign_d;
    end
  end

  // Reset gates the combinational stall so a held memop cannot re-raise it mid-reset.
  assign stall_o      = stall_c & ~rst_i;
  assign dmem_req_o   = (state_q == S_BUSY);
  assign dmem_we_o    = dmem_req_o & we_q;
  assign dmem_addr_o  = dmem_req_o ? addr_q  : 32'h0;
  assign dmem_wdata_o = dmem_req_o ? wdata_q : 32'h0;
  assign timeout_o    = (state_q == S_DONE) & abort_q;

  assign ALUResult_o  = alu_q;
  assign VALUResult_o = valu_q;
  assign MemData_o    = memdata_q;
  assign RDaddr_o     = rdaddr_q;
  assign RegWrite_o   = regwrite_q;
  assign MemToReg_o   = memtoreg_q;
  assign instr_o      = instr_q;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: ALU pass-through, loads, stores,
// misalignment, timeout and asynchronous reset during an access.
module tb_mem_stage;

  logic        clk;
  logic        rst;
  logic [31:0] alu_i, valu_i, rddata_i, instr_i;
  logic [4:0]  rdaddr_i;
  logic        regwrite_i, memtoreg_i, memread_i, memwrite_i;
  logic        ack_i;
  logic [31:0] rdata_i;

  logic        stall, req, we;
  logic [31:0] addr, wdata;
  logic [31:0] alu_o, valu_o, memdata_o, instr_o;
  logic [4:0]  rdaddr_o;
  logic        regwrite_o, memtoreg_o, misalign, timeout;

  int total;
  int bad;

  mem_stage #(.TIMEOUT(4), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .ALUResult_i(alu_i), .VALUResult_i(valu_i), .RDData_i(rddata_i),
    .RDaddr_i(rdaddr_i), .RegWrite_i(regwrite_i), .MemToReg_i(memtoreg_i),
    .MemRead_i(memread_i), .MemWrite_i(memwrite_i), .instr_i(instr_i),
    .stall_o(stall), .dmem_req_o(req), .dmem_we_o(we),
    .dmem_addr_o(addr), .dmem_wdata_o(wdata),
    .dmem_ack_i(ack_i), .dmem_rdata_i(rdata_i),
    .ALUResult_o(alu_o), .VALUResult_o(valu_o), .MemData_o(memdata_o),
    .RDaddr_o(rdaddr_o), .RegWrite_o(regwrite_o), .MemToReg_o(memtoreg_o),
    .instr_o(instr_o), .misalign_o(misalign), .timeout_o(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] valu,
                       input logic [31:0] rdd, input logic [4:0] rda,
                       input logic rw, input logic m2r, input logic mr,
                       input logic mw, input logic [31:0] ins);
    alu_i = alu; valu_i = valu; rddata_i = rdd; rdaddr_i = rda;
    regwrite_i = rw; memtoreg_i = m2r; memread_i = mr; memwrite_i = mw;
    instr_i = ins;
    #1;
  endtask

  task automatic nop();
    drive(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1; ack_i = 1'b0; rdata_i = 32'h0;
    nop();
    #12;
    total++; if ({stall, req, we, regwrite_o, memtoreg_o, misalign, timeout} !== 7'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=0", {stall, req, we, regwrite_o, memtoreg_o, misalign, timeout}); end
    total++; if ({alu_o, valu_o, memdata_o, instr_o, addr, wdata} !== 192'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", {alu_o, valu_o, memdata_o, instr_o}); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_alu();
    drive(32'h1234, 32'h55, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0013);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b exp=0", stall); end
    tick();
    total++; if (alu_o !== 32'h1234) begin bad++; $display("FAIL alu_result got=%h exp=00001234", alu_o); end
    total++; if (rdaddr_o !== 5'd5 || regwrite_o !== 1'b1) begin bad++; $display("FAIL alu_wb got rd=%0d rw=%b exp rd=5 rw=1", rdaddr_o, regwrite_o); end
    total++; if (valu_o !== 32'h55 || memdata_o !== 32'h0 || instr_o !== 32'h13) begin bad++; $display("FAIL alu_pass got v=%h m=%h i=%h", valu_o, memdata_o, instr_o); end
    nop();
  endtask

  task automatic test_load_immediate();
    drive(32'h100, 32'h0, 32'h0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_2003);
    total++; if (stall !== 1'b1 || req !== 1'b0) begin bad++; $display("FAIL ld_detect got stall=%b req=%b exp 1 0", stall, req); end
    tick();
    ack_i = 1'b1; rdata_i = 32'hDEAD_BEEF; #1;
    total++; if (stall !== 1'b1 || req !== 1'b1 || we !== 1'b0 || addr !== 32'h100) begin bad++; $display("FAIL ld_busy got stall=%b req=%b we=%b addr=%h", stall, req, we, addr); end
    total++; if (regwrite_o !== 1'b0 || rdaddr_o !== 5'd0 || instr_o !== 32'h0) begin bad++; $display("FAIL ld_bubble got rw=%b rd=%0d i=%h exp 0", regwrite_o, rdaddr_o, instr_o); end
    tick();
    ack_i = 1'b0; rdata_i = 32'h0; #1;
    total++; if (stall !== 1'b0 || req !== 1'b0 || addr !== 32'h0 || timeout !== 1'b0) begin bad++; $display("FAIL ld_done got stall=%b req=%b addr=%h to=%b", stall, req, addr, timeout); end
    tick();
    total++; if (memdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ld_data got=%h exp=deadbeef", memdata_o); end
    total++; if (regwrite_o !== 1'b1 || memtoreg_o !== 1'b1 || rdaddr_o !== 5'd7) begin bad++; $display("FAIL ld_wb got rw=%b m2r=%b rd=%0d exp 1 1 7", regwrite_o, memtoreg_o, rdaddr_o); end
    nop();
    tick();
    total++; if (regwrite_o !== 1'b0) begin bad++; $display("FAIL ld_single_rw got=%b exp=0", regwrite_o); end
  endtask

  task automatic test_store_delay();
    int req_cycles;
    req_cycles = 0;
    drive(32'h200, 32'h0, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2023);
    total++; if (stall !== 1'b1 || req !== 1'b0) begin bad++; $display("FAIL st_detect got stall=%b req=%b exp 1 0", stall, req); end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin ack_i = 1'b1; #1; end
      if (req === 1'b1) req_cycles++;
      total++; if (stall !== 1'b1 || we !== 1'b1 || addr !== 32'h200 || wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL st_busy%0d got stall=%b we=%b addr=%h wd=%h", i, stall, we, addr, wdata); end
      total++; if (regwrite_o !== 1'b0 || rdaddr_o !== 5'd0 || instr_o !== 32'h0) begin bad++; $display("FAIL st_bubble%0d got rw=%b rd=%0d i=%h", i, regwrite_o, rdaddr_o, instr_o); end
    end
    total++; if (req_cycles !== 4) begin bad++; $display("FAIL st_req_cycles got=%0d exp=4", req_cycles); end
    tick();
    ack_i = 1'b0; #1;
    total++; if ({stall, req, we} !== 3'b0 || addr !== 32'h0 || wdata !== 32'h0 || timeout !== 1'b0) begin bad++; $display("FAIL st_done got stall=%b req=%b we=%b to=%b", stall, req, we, timeout); end
    tick();
    total++; if (memdata_o !== 32'h0 || instr_o !== 32'h2023 || alu_o !== 32'h200) begin bad++; $display("FAIL st_wb got m=%h i=%h a=%h", memdata_o, instr_o, alu_o); end
    nop();
  endtask

  task automatic test_misaligned();
    drive(32'h102, 32'h0, 32'h0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_2083);
    total++; if (stall !== 1'b0 || req !== 1'b0) begin bad++; $display("FAIL mis_detect got stall=%b req=%b exp 0 0", stall, req); end
    tick();
    total++; if (misalign !== 1'b1 || req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL mis_pulse got mis=%b req=%b stall=%b exp 1 0 0", misalign, req, stall); end
    total++; if (regwrite_o !== 1'b0 || memtoreg_o !== 1'b0 || alu_o !== 32'h102 || rdaddr_o !== 5'd9) begin bad++; $display("FAIL mis_wb got rw=%b m2r=%b a=%h rd=%0d", regwrite_o, memtoreg_o, alu_o, rdaddr_o); end
    nop();
    tick();
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL mis_single got=%b exp=0", misalign); end
  endtask

  task automatic test_timeout();
    drive(32'h300, 32'h0, 32'h0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_2183);
    tick();
    for (int i = 0; i < 4; i++) begin
      total++; if (req !== 1'b1 || timeout !== 1'b0) begin bad++; $display("FAIL to_busy%0d got req=%b to=%b exp 1 0", i, req, timeout); end
      tick();
    end
    total++; if (req !== 1'b0 || timeout !== 1'b1 || stall !== 1'b0) begin bad++; $display("FAIL to_done got req=%b to=%b stall=%b exp 0 1 0", req, timeout, stall); end
    tick();
    total++; if (regwrite_o !== 1'b0 || memtoreg_o !== 1'b0 || memdata_o !== 32'h0 || timeout !== 1'b0 || rdaddr_o !== 5'd3) begin bad++; $display("FAIL to_wb got rw=%b m2r=%b m=%h to=%b rd=%0d", regwrite_o, memtoreg_o, memdata_o, timeout, rdaddr_o); end
    nop();
  endtask

  task automatic test_back_to_back();
    drive(32'h10, 32'h0, 32'h0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1);
    tick();
    ack_i = 1'b1; rdata_i = 32'h1111_1111; #1;
    tick();
    ack_i = 1'b0; #1;
    total++; if (req !== 1'b0) begin bad++; $display("FAIL b2b_gap got req=%b exp=0", req); end
    tick();
    drive(32'h14, 32'h0, 32'h2222_2222, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2);
    total++; if (memdata_o !== 32'h1111_1111 || req !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL b2b_first got m=%h req=%b stall=%b", memdata_o, req, stall); end
    tick();
    total++; if (req !== 1'b1 || we !== 1'b1 || addr !== 32'h14 || wdata !== 32'h2222_2222) begin bad++; $display("FAIL b2b_second got req=%b we=%b addr=%h wd=%h", req, we, addr, wdata); end
    ack_i = 1'b1; #1;
    tick();
    ack_i = 1'b0; #1;
    tick();
    total++; if (memdata_o !== 32'h0 || instr_o !== 32'h2) begin bad++; $display("FAIL b2b_store_wb got m=%h i=%h", memdata_o, instr_o); end
    nop();
  endtask

  task automatic test_reset_mid();
    drive(32'hCAFE, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 32'h3);
    tick();
    drive(32'h400, 32'h0, 32'h0, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 32'h4);
    tick();
    tick();
    total++; if (req !== 1'b1 || alu_o !== 32'hCAFE) begin bad++; $display("FAIL rst_pre got req=%b a=%h exp 1 cafe", req, alu_o); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (req !== 1'b0 || stall !== 1'b0 || addr !== 32'h0) begin bad++; $display("FAIL rst_async got req=%b stall=%b addr=%h exp 0", req, stall, addr); end
    total++; if (alu_o !== 32'h0 || regwrite_o !== 1'b0) begin bad++; $display("FAIL rst_outs got a=%h rw=%b exp 0", alu_o, regwrite_o); end
    nop();
    tick();
    rst = 1'b0;
    ack_i = 1'b1; rdata_i = 32'hBAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (req !== 1'b0 || stall !== 1'b0 || memdata_o !== 32'h0) begin bad++; $display("FAIL rst_ack_ignored%0d got req=%b stall=%b m=%h", i, req, stall, memdata_o); end
      tick();
    end
    ack_i = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_alu();
    test_load_immediate();
    test_store_delay();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
